// File: rtl/station_dispatch.sv
// -----------------------------------------------------------------------------
// station_dispatch
//   Buffers decoded iops in a small FIFO and hands the oldest one to a free
//   reservation station. Station choice is round-robin over four stations.
//
//   Optional build macro:
//     DISPATCH_BYPASS_EN  When the FIFO is empty and a station is free, the
//                         decoder iop is fed straight to the station in the same
//                         cycle. It is not written into the FIFO.
//
//   Parameters:
//     DEPTH         FIFO entry count (2, 4 or 8)
//
//   Ports:
//     clk           sole clock, rising edge
//     rst           synchronous active-high reset
//     dec_valid     decoder presents an iop
//     dec_iop       decoded iop word
//     dec_iop_init  station initial state
//     dec_pc        iop program counter
//     dec_k16       iop 16-bit constant
//     dec_ready     dispatcher accepts dec_* on this edge
//     flush         drop all buffered iops and suppress dispatch this cycle
//     st_complete   bit n high = station n free
//     id_feed       one-hot load strobe to the stations (zero = no load)
//     id_iop, id_iop_init, id_pc, id_k16   shared station buses
//     fifo_count    number of buffered iops
// -----------------------------------------------------------------------------
module station_dispatch #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic [31:0]              dec_iop,
    input  logic [2:0]               dec_iop_init,
    input  logic [15:0]              dec_pc,
    input  logic [15:0]              dec_k16,
    output logic                     dec_ready,
    input  logic                     flush,
    input  logic [3:0]               st_complete,
    output logic [3:0]               id_feed,
    output logic [31:0]              id_iop,
    output logic [2:0]               id_iop_init,
    output logic [15:0]              id_pc,
    output logic [15:0]              id_k16,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] iop;
        logic [2:0]  init;
        logic [15:0] pc;
        logic [15:0] k16;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          dec_entry;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [1:0]      rr_ptr;

    logic            fifo_empty;
    logic            src_valid;
    logic            feed_en;
    logic            bypass_take;
    logic            push;
    logic            pop;
    logic            found;
    logic [1:0]      sel;
    logic [1:0]      idx;

    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    assign dec_entry  = '{iop: dec_iop, init: dec_iop_init, pc: dec_pc, k16: dec_k16};
    assign fifo_count = count;

    // Readiness looks only at the registered count, so a same-cycle pop never
    // opens an extra slot.
    assign dec_ready  = ~rst & (count != CW'(DEPTH));

    // Round-robin pick: first free station starting at rr_ptr, wrapping mod 4.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        found = 1'b0;
        sel   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && st_complete[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

`ifdef DISPATCH_BYPASS_EN
    assign src_valid   = ~fifo_empty | dec_valid;
    assign bypass_take = fifo_empty & feed_en;
`else
    assign src_valid   = ~fifo_empty;
    assign bypass_take = 1'b0;
`endif

    assign feed_en = ~rst & ~flush & src_valid & found;
    assign pop     = feed_en & ~fifo_empty;
    assign push    = dec_valid & dec_ready & ~flush & ~bypass_take;
    assign id_feed = feed_en ? (4'b0001 << sel) : 4'b0000;

    always_comb begin
        id_iop      = head.iop;
        id_iop_init = head.init;
        id_pc       = head.pc;
        id_k16      = head.k16;
        if (fifo_empty) begin
            id_iop      = dec_entry.iop;
            id_iop_init = dec_entry.init;
            id_pc       = dec_entry.pc;
            id_k16      = dec_entry.k16;
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= 2'd0;
        end else if (flush) begin
            // Empty the FIFO. The same-cycle push is already gated off, and rr_ptr holds.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;   // DEPTH is a power of two, so the pointer wraps naturally
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (feed_en) begin
                rr_ptr <= sel + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_station_dispatch.sv
// -----------------------------------------------------------------------------
// tb_station_dispatch
//   Scoreboard bench for station_dispatch. The stimulus side pushes each
//   accepted iop into exp_q. The monitor compares the DUT outputs against a
//   queue-based reference model, then pops exp_q when a dispatch is due.
//   The bench honours DISPATCH_BYPASS_EN if it is defined.
// -----------------------------------------------------------------------------
module tb_station_dispatch;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] iop;
        logic [2:0]  init;
        logic [15:0] pc;
        logic [15:0] k16;
    } item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dec_valid = 1'b0;
    logic [31:0]   dec_iop = '0;
    logic [2:0]    dec_iop_init = '0;
    logic [15:0]   dec_pc = '0;
    logic [15:0]   dec_k16 = '0;
    logic          dec_ready;
    logic          flush = 1'b0;
    logic [3:0]    st_complete = '0;
    logic [3:0]    id_feed;
    logic [31:0]   id_iop;
    logic [2:0]    id_iop_init;
    logic [15:0]   id_pc;
    logic [15:0]   id_k16;
    logic [CW-1:0] fifo_count;

    int     n_checks = 0;
    int     n_fail   = 0;
    item_t  exp_q[$];
    int     m_rr = 0;
    logic   bypass_taken = 1'b0;
    logic   mon_en = 1'b1;

    station_dispatch #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_iop(dec_iop), .dec_iop_init(dec_iop_init),
        .dec_pc(dec_pc), .dec_k16(dec_k16), .dec_ready(dec_ready),
        .flush(flush), .st_complete(st_complete),
        .id_feed(id_feed), .id_iop(id_iop), .id_iop_init(id_iop_init),
        .id_pc(id_pc), .id_k16(id_k16), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int rr, input logic [3:0] st);
        for (int k = 0; k < 4; k++) begin
            if (st[(rr + k) % 4]) return (rr + k) % 4;
        end
        return -1;
    endfunction

    // Monitor and reference model: runs every cycle, 2 time units after the inputs change.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (rst) begin
                check("rst_feed", 64'(id_feed), 64'd0);
                check("rst_ready", 64'(dec_ready), 64'd0);
                exp_q.delete();
                m_rr = 0;
            end else begin
                int    n;
                item_t h;
                check("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
                check("dec_ready", 64'(dec_ready), 64'(exp_q.size() != DEPTH));
                n = pick(m_rr, st_complete);
                if (flush || n < 0) begin
                    check("feed_idle", 64'(id_feed), 64'd0);
                end else if (exp_q.size() > 0) begin
                    h = exp_q.pop_front();
                    check("feed_sel", 64'(id_feed), 64'(4'b0001 << n));
                    check("feed_pc", 64'(id_pc), 64'(h.pc));
                    check("feed_iop", 64'(id_iop), 64'(h.iop));
                    check("feed_init", 64'(id_iop_init), 64'(h.init));
                    check("feed_k16", 64'(id_k16), 64'(h.k16));
                    m_rr = (n + 1) % 4;
`ifdef DISPATCH_BYPASS_EN
                end else if (dec_valid) begin
                    check("bypass_sel", 64'(id_feed), 64'(4'b0001 << n));
                    check("bypass_pc", 64'(id_pc), 64'(dec_pc));
                    check("bypass_iop", 64'(id_iop), 64'(dec_iop));
                    bypass_taken = 1'b1;
                    m_rr = (n + 1) % 4;
`endif
                end else begin
                    check("feed_empty", 64'(id_feed), 64'd0);
                end
                if (flush) exp_q.delete();
            end
        end
    end

    // Stimulus: drive for one cycle, then push the iop into the scoreboard if it is accepted.
    task automatic drive(input logic r, input logic v, input logic [31:0] iop, input logic [2:0] init,
                         input logic [15:0] pc, input logic [15:0] k16, input logic f,
                         input logic [3:0] st);
        logic rdy;
        item_t it;
        @(negedge clk);
        rst = r; dec_valid = v; dec_iop = iop; dec_iop_init = init;
        dec_pc = pc; dec_k16 = k16; flush = f; st_complete = st;
        bypass_taken = 1'b0;
        rdy = (exp_q.size() != DEPTH);
        #3;
        if (!r && v && rdy && !f && !bypass_taken) begin
            it.iop = iop; it.init = init; it.pc = pc; it.k16 = k16;
            exp_q.push_back(it);
        end
    endtask

    task automatic idle(input logic [3:0] st, input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, st);
    endtask

    initial begin
        // Reset, then accept one iop and dispatch it to station 0.
        drive(1'b1, 1'b1, 32'h1, 3'd1, 16'h0001, 16'h0, 1'b0, 4'b1111);
        drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 4'b1111);
        drive(1'b0, 1'b1, 32'hA5A5_0001, 3'd2, 16'h1000, 16'h1234, 1'b0, 4'b1111);
        idle(4'b1111, 2);
        // Three back-to-back iops with no free station; the third is held off.
        drive(1'b0, 1'b1, 32'h11, 3'd1, 16'h0101, 16'h1, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 32'h22, 3'd0, 16'h0202, 16'h2, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 32'h33, 3'd3, 16'h0303, 16'h3, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 32'h33, 3'd3, 16'h0303, 16'h3, 1'b0, 4'b0100);
        idle(4'b0100, 3);   // this leaves the round-robin pointer at 3
        // With the pointer at 3, the pick order is station 3 first, then station 0.
        drive(1'b0, 1'b1, 32'h44, 3'd0, 16'h0404, 16'h4, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 32'h55, 3'd0, 16'h0505, 16'h5, 1'b0, 4'b0000);
        idle(4'b1001, 2);
        idle(4'b1111, 2);
        // Flush with the FIFO full and a same-cycle push pending.
        drive(1'b0, 1'b1, 32'h66, 3'd1, 16'h0606, 16'h6, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 32'h77, 3'd1, 16'h0707, 16'h7, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 32'hDEAD, 3'd7, 16'hDEAD, 16'hD, 1'b1, 4'b1111);
        idle(4'b1111, 2);
        // With one entry buffered, push and dispatch on the same edge.
        drive(1'b0, 1'b1, 32'hAA, 3'd2, 16'h0A0A, 16'hA, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 32'hBB, 3'd2, 16'h0B0B, 16'hB, 1'b0, 4'b1111);
        idle(4'b1111, 3);
        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6), $urandom,
                  3'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom));
        end
        // Drain the FIFO, bounded by a cycle budget.
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(4'b1111, 1);
        idle(4'b1111, 1);
        mon_en = 1'b0;
        check("drained", 64'(exp_q.size()), 64'd0);
        check("final_count", 64'(fifo_count), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/station_dispatch.md
STATION_DISPATCH -- requirements
Module: station_dispatch

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the dispatch FIFO entry count; legal values 2, 4, 8.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 dec_valid  in  1  decoder presents an iop this cycle.
REQ-005 dec_iop  in  32  decoded internal operation word.
REQ-006 dec_iop_init  in  3  station initial state for this iop.
REQ-007 dec_pc  in  16  iop program counter.
REQ-008 dec_k16  in  16  iop 16-bit constant.
REQ-009 dec_ready  out  1  dispatcher accepts dec_* on this edge when dec_valid=1.
REQ-010 flush  in  1  discard all buffered iops and suppress dispatch this cycle.
REQ-011 st_complete  in  4  per-station id_complete, bit n = station n free.
REQ-012 id_feed  out  4  one-hot (or zero) load strobe, bit n to station n.
REQ-013 id_iop  out  32  shared iop bus to all stations.
REQ-014 id_iop_init  out  3  shared initial-state bus.
REQ-015 id_pc  out  16  shared pc bus.
REQ-016 id_k16  out  16  shared constant bus.
REQ-017 fifo_count  out  log2(DEPTH)+1  buffered iop count.

Function
REQ-018 Accept: dec_valid & dec_ready & ~flush SHALL push dec_* into the FIFO tail.
REQ-019 dec_ready SHALL equal (fifo_count != DEPTH), from registered count only, independent of same-cycle pop.
REQ-020 Dispatch: FIFO non-empty & |st_complete & ~flush SHALL assert exactly one id_feed bit combinationally and pop the head on that edge.
REQ-021 id_iop/id_iop_init/id_pc/id_k16 SHALL present the FIFO head whenever it is non-empty; value irrelevant when id_feed=0.
REQ-022 Station choice SHALL be round-robin: first n with st_complete[n]=1, scanning rr_ptr, rr_ptr+1, ... mod 4.
REQ-023 After a dispatch to station n, rr_ptr SHALL become (n+1) mod 4; unchanged otherwise.
REQ-024 No free station: id_feed=0, head retained, rr_ptr unchanged.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO order strictly preserved.
REQ-026 Pointers SHALL wrap modulo DEPTH; push at full and pop at empty SHALL never occur.
REQ-027 Minimum latency accept-to-id_feed: 1 cycle (no bypass unless REQ-033).
REQ-028 flush SHALL, on that edge, empty the FIFO, drop any same-cycle push, force id_feed=0; rr_ptr unchanged.
REQ-029 An iop with id_iop_init=000 SHALL be dispatched normally (station stays free; no special case).

Reset
REQ-030 rst=1 at a rising edge SHALL set fifo_count=0, read/write pointers=0, rr_ptr=0.
REQ-031 While rst=1, id_feed SHALL be 0 and dec_ready SHALL be 0; first accept possible on the edge after rst deasserts.
REQ-032 Reset mid-operation SHALL discard all buffered iops; no partial dispatch.

Configuration
REQ-033 DISPATCH_BYPASS_EN defined: when FIFO empty, dec_valid=1, ~flush and a station free, the decoder iop SHALL be fed directly that cycle (id_* = dec_*, id_feed set, no FIFO push, dec_ready=1); latency 0.
REQ-034 DISPATCH_BYPASS_EN undefined: every iop passes through the FIFO; latency per REQ-027.

Verification
REQ-035 After reset, push iop pc=0x1000, st_complete=4'b1111 -> next cycle id_feed=4'b0001, id_pc=0x1000, fifo_count 1->0.
REQ-036 Push 3 iops back-to-back with st_complete=0, DEPTH=2 -> dec_ready low after 2nd, 3rd held; release st_complete=4'b0100 -> id_feed=4'b0100 carrying 1st iop.
REQ-037 rr_ptr=3, st_complete=4'b1001 -> id_feed=4'b1000, then rr_ptr=0 -> next dispatch with 4'b1001 gives 4'b0001.
REQ-038 FIFO holding 2, flush=1 with dec_valid=1 and st_complete=4'b1111 -> id_feed=0, fifo_count=0 next cycle, dropped iop never appears.
REQ-039 fifo_count=1, push and dispatch same edge -> fifo_count stays 1, order pc A then B preserved.
REQ-040 With DISPATCH_BYPASS_EN, empty FIFO, dec_valid=1 pc=0x2000, st_complete=4'b0010 -> same cycle id_feed=4'b0010, id_pc=0x2000, fifo_count stays 0.
